// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the fifo_stream_rd read-side adapter.
// Occupancy encoding is the numeric word count held downstream of the RAM FIFO.
package fifo_stream_pkg;

   // Words the adapter may hold or have in flight at once.
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   // Number of buffered words represented by an occupancy state.
   function automatic logic [1:0] occ_words(input logic [1:0] st);
      return st;
   endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Head/skid storage for fifo_stream_rd: steers captured RAM words into the head
// (which drives o_tdata) or the skid register, and tracks occupancy.
module fifo_stream_skid
   import fifo_stream_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cap_i,     // RAM read data is valid this cycle
   input  logic              xfer_i,    // head word leaves downstream this cycle
   input  logic [DATA_W-1:0] data_i,
   output logic [1:0]        state_o,
   output logic [DATA_W-1:0] tdata_o
);

   occ_e              state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;

   // Occupancy and storage registers; reset drops any buffered words.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   // Steering: a capture lands in the head when it is free or draining with no
   // skid word behind it, else in the skid; a transfer promotes skid to head.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (cap_i) begin
               head_d  = data_i;
               state_d = ONE;
            end
         end
         ONE: begin
            if (cap_i && xfer_i) begin
               head_d = data_i;
            end else if (cap_i) begin
               skid_d  = data_i;
               state_d = TWO;
            end else if (xfer_i) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // The credit check upstream guarantees no capture arrives here.
            if (xfer_i) begin
               head_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign state_o = state_q;
   assign tdata_o = head_q;

endmodule

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: turns a RAM FIFO with one-cycle read latency into a
// valid/ready stream. Pops are issued only when the two-entry buffer has room
// for the word after accounting for one in flight and one leaving this cycle.
// Optional build macro FIFO_STREAM_RD_STATS_EN adds o_xfer_cnt, a wrapping
// 32-bit count of completed downstream transfers.
module fifo_stream_rd
   import fifo_stream_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   output logic              o_fifo_rden,
   input  logic [DATA_W-1:0] i_fifo_rddata,
   input  logic              i_fifo_empty,
   output logic              o_tvalid,
   output logic [DATA_W-1:0] o_tdata,
   input  logic              i_tready
`ifdef FIFO_STREAM_RD_STATS_EN
   ,
   output logic [31:0]       o_xfer_cnt
`endif
);

   logic       inflight_q, inflight_d;
   logic [1:0] state;
   logic       xfer;
   logic [2:0] credit_used;

   assign o_tvalid = (state != EMPTY);
   assign xfer     = o_tvalid & i_tready;

   // Words committed downstream once this cycle's transfer is accounted for.
   assign credit_used = {1'b0, occ_words(state)} + {2'b00, inflight_q} - {2'b00, xfer};
   assign o_fifo_rden = rstn & ~i_fifo_empty & (credit_used < 3'(SKID_DEPTH));
   assign inflight_d  = o_fifo_rden;

   // In-flight flag: the RAM returns data the cycle after a pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   fifo_stream_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .rstn    (rstn),
      .cap_i   (inflight_q),
      .xfer_i  (xfer),
      .data_i  (i_fifo_rddata),
      .state_o (state),
      .tdata_o (o_tdata)
   );

`ifdef FIFO_STREAM_RD_STATS_EN
   logic [31:0] xfer_cnt_q, xfer_cnt_d;

   assign xfer_cnt_d = xfer ? xfer_cnt_q + 32'd1 : xfer_cnt_q;

   // Transfer counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: doc/fifo_stream_rd.md
FIFO_STREAM_RD -- requirements
Module: fifo_stream_rd

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port o_fifo_rden  output  1  pop request to upstream RAM FIFO.
REQ-005 SHALL have port i_fifo_rddata  input  DATA_W  upstream read data, valid in the cycle after a pop.
REQ-006 SHALL have port i_fifo_empty  input  1  upstream empty flag.
REQ-007 SHALL have port o_tvalid  output  1  downstream data valid.
REQ-008 SHALL have port o_tdata  output  DATA_W  downstream data.
REQ-009 SHALL have port i_tready  input  1  downstream ready.
REQ-010 SHALL have port o_xfer_cnt  output  32  count of completed downstream transfers; present only with FIFO_STREAM_RD_STATS_EN.

Function
REQ-011 SHALL treat a downstream transfer as any cycle with o_tvalid=1 and i_tready=1.
REQ-012 SHALL hold a 2-entry internal buffer: head register driving o_tdata, plus skid register.
REQ-013 SHALL track occupancy with states EMPTY (0), ONE (1) and TWO (2), plus a 1-bit in-flight flag set in the cycle after o_fifo_rden=1.
REQ-014 SHALL drive o_fifo_rden=1 iff rstn=1, i_fifo_empty=0, and (occupancy + in-flight - transfer-this-cycle) < 2.
REQ-015 SHALL capture i_fifo_rddata exactly one cycle after the pop that requested it, with no other capture condition.
REQ-016 SHALL write a captured word into the head if the head is free or the head is transferring this cycle with the skid empty; otherwise it SHALL write it into the skid.
REQ-017 SHALL move skid into head on a transfer when the skid is occupied.
REQ-018 State transitions, where "cap" is a capture and "xfer" is a transfer:
- EMPTY: goes to ONE on cap.
- ONE: goes to TWO on cap without xfer, goes to EMPTY on xfer without cap, and stays in ONE on both or neither.
- TWO: goes to ONE on xfer.
- TWO SHALL never coincide with a capture.
REQ-019 SHALL drive o_tvalid=1 iff state is not EMPTY.
REQ-020 SHALL hold o_tdata stable while o_tvalid=1 and i_tready=0.
REQ-021 SHALL deliver words in pop order with no loss or duplication.
REQ-022 SHALL sustain one transfer per cycle in steady state when i_fifo_empty=0 and i_tready=1.
REQ-023 SHALL give first-word latency from rden to o_tvalid of 2 cycles: pop in cycle N, capture at end of N+1, o_tvalid=1 in N+2.
REQ-024 SHALL never pop while i_fifo_empty=1, and SHALL ignore i_tready while o_tvalid=0.

Reset
REQ-025 SHALL, while rstn=0, immediately force o_tvalid=0, o_tdata=0, o_fifo_rden=0, state EMPTY, in-flight=0 and o_xfer_cnt=0.
REQ-026 SHALL discard any in-flight or buffered word on a reset mid-operation, and SHALL resume popping the cycle after rstn rises if i_fifo_empty=0.

Configuration
REQ-027 SHALL, with FIFO_STREAM_RD_STATS_EN defined, provide o_xfer_cnt incrementing by 1 per transfer and wrapping 0xFFFFFFFF->0.
REQ-028 SHALL, without FIFO_STREAM_RD_STATS_EN, remove both the o_xfer_cnt port and the counter logic, leaving all other behaviour identical.

Structure
REQ-029 SHALL take the state enum typedef (EMPTY/ONE/TWO) and constant SKID_DEPTH=2 from shared package fifo_stream_pkg.
REQ-030 SHALL place head/skid storage and steering in one sub-module, fifo_stream_skid; pop and credit logic SHALL stay in the top.

Verification
REQ-031 Bench SHALL preload FIFO with 0x11,0x22,0x33 and hold tready=1 -> rden in cycles 0-2, tdata 0x11,0x22,0x33 in cycles 2-4, tvalid=0 in cycle 5.
REQ-032 Bench SHALL preload 4 words and hold tready=0 -> exactly 2 pops, tvalid=1, tdata=first word stable, and rden=0 thereafter.
REQ-033 Bench SHALL then raise tready from the REQ-032 state -> all 4 words delivered in order on 4 consecutive cycles once the stream is primed.
REQ-034 Bench SHALL stream 16 words with tready toggling 1,0,1,0 -> all 16 delivered in order with no rden while empty=1.
REQ-035 Bench SHALL assert rstn=0 mid-stream with occupancy TWO -> tvalid=0 and tdata=0 asynchronously, and o_xfer_cnt=0 (STATS_EN build).
REQ-036 Bench SHALL preset o_xfer_cnt near 0xFFFFFFFF via forced state and perform 2 transfers -> count reads 0x00000000 and then 0x00000001 (STATS_EN build).
